// File: rtl/key_search_if.sv
// key_search_if: control, ARC4 core and plaintext memory signals of key_search.
// slave is the search engine side, master is the environment side.
interface key_search_if;
   logic        en;
   logic        rdy;
   logic [23:0] arc4_key;
   logic        arc4_en;
   logic        arc4_rdy;
   logic [7:0]  pt_addr;
   logic [7:0]  pt_rddata;
   logic        stop;
   logic [23:0] key;
   logic        key_valid;

   modport slave (
      input  en, arc4_rdy, pt_rddata, stop,
      output rdy, arc4_key, arc4_en, pt_addr, key, key_valid
   );

   modport master (
      output en, arc4_rdy, pt_rddata, stop,
      input  rdy, arc4_key, arc4_en, pt_addr, key, key_valid
   );
endinterface

// File: rtl/key_search.sv
// key_search: steps ARC4 keys until the plaintext is all printable or keys run out.
// KEY_SEARCH_STOP_EN enables the sibling abort input (stop).
module key_search #(
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter int unsigned KEY_STEP  = 1
) (
   input logic         clk,
   input logic         rst_n,
   key_search_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, LAUNCH, WAIT, RD_LEN, RD_CHR, CHECK, NEXT, DONE
   } state_t;

   localparam logic [24:0] LP_STEP = 25'(KEY_STEP);

   state_t      r_state;
   logic [23:0] r_cand;
   logic [23:0] r_arc4_key;
   logic [23:0] r_key;
   logic [7:0]  r_len;
   logic [7:0]  r_idx;
   logic [7:0]  r_pt_addr;
   logic        r_hold;
   logic        r_rdy;
   logic        r_key_valid;

   logic [24:0] w_sum;
   logic        w_print;
   logic        w_len_zero;
   logic        w_last;
   logic        w_success;
   logic        w_stop;

   assign w_sum      = {1'b0, r_cand} + LP_STEP;
   assign w_print    = (bus.pt_rddata >= 8'h20) &&
                       (bus.pt_rddata <= 8'h7E);
   assign w_len_zero = (r_state == RD_LEN) && r_hold &&
                       (bus.pt_rddata == 8'h00);
   assign w_last     = (r_state == CHECK) && w_print &&
                       (r_idx == r_len);
   assign w_success  = w_len_zero || w_last;

`ifdef KEY_SEARCH_STOP_EN
   assign w_stop = bus.stop && (r_state != IDLE) &&
                   (r_state != DONE) && !w_success;
`else
   assign w_stop = bus.stop & 1'b0;
`endif

   // Pulse only while the core reports idle, so it can never be missed.
   assign bus.arc4_en   = (r_state == LAUNCH) && bus.arc4_rdy && !w_stop;
   assign bus.arc4_key  = r_arc4_key;
   assign bus.pt_addr   = r_pt_addr;
   assign bus.rdy       = r_rdy;
   assign bus.key       = r_key;
   assign bus.key_valid = r_key_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cand      <= 24'h000000;
         r_arc4_key  <= 24'h000000;
         r_key       <= 24'h000000;
         r_len       <= 8'h00;
         r_idx       <= 8'h00;
         r_pt_addr   <= 8'h00;
         r_hold      <= 1'b0;
         r_rdy       <= 1'b1;
         r_key_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.en && r_rdy) begin
                  r_cand      <= KEY_START;
                  r_arc4_key  <= KEY_START;
                  r_key_valid <= 1'b0;
                  r_rdy       <= 1'b0;
                  r_state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (bus.arc4_rdy) begin
                  r_hold  <= 1'b1;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               // First cycle after the pulse the core may not yet show busy.
               if (r_hold) begin
                  r_hold <= 1'b0;
               end else if (bus.arc4_rdy) begin
                  r_pt_addr <= 8'h00;
                  r_state   <= RD_LEN;
               end
            end
            RD_LEN: begin
               if (!r_hold) begin
                  r_hold <= 1'b1;
               end else begin
                  r_hold <= 1'b0;
                  r_len  <= bus.pt_rddata;
                  r_idx  <= 8'h01;
                  if (w_len_zero) begin
                     r_key       <= r_cand;
                     r_key_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_pt_addr <= 8'h01;
                     r_state   <= RD_CHR;
                  end
               end
            end
            RD_CHR: begin
               r_state <= CHECK;
            end
            CHECK: begin
               if (!w_print) begin
                  r_state <= NEXT;
               end else if (w_last) begin
                  r_key       <= r_cand;
                  r_key_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_idx     <= r_idx + 8'h01;
                  r_pt_addr <= r_idx + 8'h01;
                  r_state   <= RD_CHR;
               end
            end
            NEXT: begin
               if (w_sum[24]) begin
                  r_key_valid <= 1'b0;
                  r_state     <= DONE;
               end else begin
                  r_cand     <= w_sum[23:0];
                  r_arc4_key <= w_sum[23:0];
                  r_state    <= LAUNCH;
               end
            end
            DONE: begin
               r_state <= DONE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
         if (w_stop) begin
            r_state     <= DONE;
            r_key_valid <= 1'b0;
            r_hold      <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_key_search.sv
// tb_key_search: three key_search instances against behavioural ARC4 cores
// and plaintext memories, with directed vectors and corner sequences.
module tb_key_search;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   key_search_if u_if0 ();
   key_search_if u_if1 ();
   key_search_if u_if2 ();

   key_search #(.KEY_START(24'h000001), .KEY_STEP(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(u_if0));
   key_search #(.KEY_START(24'hFFFFFD), .KEY_STEP(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(u_if1));
   key_search #(.KEY_START(24'h000001), .KEY_STEP(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(u_if2));

   int checks = 0;
   int errors = 0;

   logic [23:0] t_match;
   logic [7:0]  t_len, t_b1, t_b2, t_b3, t_bad, t_badidx;

   typedef struct {
      logic [23:0] match;
      logic [7:0]  len, b1, b2, b3, bad, badidx;
      logic [23:0] exp_key;
      logic        exp_valid;
      int          exp_pulses;
      logic [7:0]  exp_maxrd;
   } vec_t;

   function automatic logic [7:0] pt0(input logic [23:0] k,
                                      input logic [7:0] a);
      if (k == t_match) begin
         if (a == 8'd0) return t_len;
         if (a == 8'd1) return t_b1;
         if (a == 8'd2) return t_b2;
         if (a == 8'd3) return t_b3;
         return 8'h2E;
      end
      if (a == 8'd0) return 8'd3;
      if (a == t_badidx) return t_bad;
      return 8'h41;
   endfunction

   function automatic logic [7:0] pt1(input logic [7:0] a);
      return (a == 8'd0) ? 8'd1 : 8'h7F;
   endfunction

   function automatic logic [7:0] pt2(input logic [23:0] k,
                                      input logic [7:0] a);
      if (a == 8'd0) return 8'd2;
      if (k == 24'd4 || k == 24'd7) return (a == 8'd1) ? 8'h6F : 8'h6B;
      return (a == 8'd1) ? 8'h00 : 8'h41;
   endfunction

   int          busy0, busy1, busy2;
   logic [23:0] ck0, ck1, ck2;
   logic [7:0]  max0;
   int          p0 = 0, p1 = 0, p2 = 0;
   int          viol = 0;
   logic        q0 = 1'b0, q1 = 1'b0, q2 = 1'b0;

   assign u_if0.arc4_rdy = (busy0 == 0);
   assign u_if1.arc4_rdy = (busy1 == 0);
   assign u_if2.arc4_rdy = (busy2 == 0);
   assign u_if1.stop = 1'b0;
   assign u_if2.stop = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy0 <= 0; busy1 <= 0; busy2 <= 0;
         ck0 <= '0; ck1 <= '0; ck2 <= '0;
         max0 <= '0;
         u_if0.pt_rddata <= '0;
         u_if1.pt_rddata <= '0;
         u_if2.pt_rddata <= '0;
      end else begin
         if (u_if0.arc4_en) begin
            busy0 <= 3; ck0 <= u_if0.arc4_key;
         end else if (busy0 > 0) busy0 <= busy0 - 1;
         if (u_if1.arc4_en) begin
            busy1 <= 3; ck1 <= u_if1.arc4_key;
         end else if (busy1 > 0) busy1 <= busy1 - 1;
         if (u_if2.arc4_en) begin
            busy2 <= 3; ck2 <= u_if2.arc4_key;
         end else if (busy2 > 0) busy2 <= busy2 - 1;
         u_if0.pt_rddata <= pt0(ck0, u_if0.pt_addr);
         u_if1.pt_rddata <= pt1(u_if1.pt_addr);
         u_if2.pt_rddata <= pt2(ck2, u_if2.pt_addr);
         if (ck0 != t_match && u_if0.pt_addr > max0)
            max0 <= u_if0.pt_addr;
      end
   end

   always @(posedge clk) begin
      if (u_if0.arc4_en) p0 <= p0 + 1;
      if (u_if1.arc4_en) p1 <= p1 + 1;
      if (u_if2.arc4_en) p2 <= p2 + 1;
   end

   // Start pulses must be single-cycle and only toward an idle core.
   always @(negedge clk) begin
      if (rst_n) begin
         viol <= viol
            + int'(u_if0.arc4_en && (!u_if0.arc4_rdy || q0))
            + int'(u_if1.arc4_en && (!u_if1.arc4_rdy || q1))
            + int'(u_if2.arc4_en && (!u_if2.arc4_rdy || q2));
      end
      q0 <= u_if0.arc4_en;
      q1 <= u_if1.arc4_en;
      q2 <= u_if2.arc4_en;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_en0();
      u_if0.en = 1'b1;
      @(negedge clk);
      u_if0.en = 1'b0;
   endtask

   task automatic wait_valid0(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (u_if0.key_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic load(input vec_t v);
      t_match = v.match; t_len = v.len;
      t_b1 = v.b1; t_b2 = v.b2; t_b3 = v.b3;
      t_bad = v.bad; t_badidx = v.badidx;
   endtask

   initial begin
      vec_t vt[5];
      bit   ok;
      int   base, base1, base2;

      vt[0] = '{24'd5, 8'd3, 8'h61, 8'h62, 8'h63, 8'h01, 8'd1,
                24'd5, 1'b1, 5, 8'd1};
      vt[1] = '{24'd1, 8'd0, 8'h00, 8'h00, 8'h00, 8'h01, 8'd1,
                24'd1, 1'b1, 1, 8'd0};
      vt[2] = '{24'd3, 8'd3, 8'h20, 8'h7E, 8'h41, 8'h7F, 8'd3,
                24'd3, 1'b1, 3, 8'd3};
      vt[3] = '{24'd2, 8'd2, 8'h68, 8'h69, 8'h00, 8'h1F, 8'd2,
                24'd2, 1'b1, 2, 8'd2};
      vt[4] = '{24'd4, 8'd1, 8'h7E, 8'h00, 8'h00, 8'h80, 8'd1,
                24'd4, 1'b1, 4, 8'd1};

      u_if0.en = 1'b0; u_if1.en = 1'b0; u_if2.en = 1'b0;
      u_if0.stop = 1'b0;
      load(vt[0]);
      do_reset();

      check("rst_rdy", 32'(u_if0.rdy), 32'd1);
      check("rst_arc4_en", 32'(u_if0.arc4_en), 32'd0);
      check("rst_arc4_key", 32'(u_if0.arc4_key), 32'd0);
      check("rst_pt_addr", 32'(u_if0.pt_addr), 32'd0);
      check("rst_key", 32'(u_if0.key), 32'd0);
      check("rst_key_valid", 32'(u_if0.key_valid), 32'd0);

      for (int i = 0; i < 5; i++) begin
         load(vt[i]);
         do_reset();
         base = p0;
         pulse_en0();
         wait_valid0(ok);
         check("vec_timeout", 32'(ok), 32'd1);
         check("vec_key", 32'(u_if0.key), 32'(vt[i].exp_key));
         check("vec_valid", 32'(u_if0.key_valid), 32'(vt[i].exp_valid));
         check("vec_pulses", 32'(p0 - base), 32'(vt[i].exp_pulses));
         check("vec_maxrd", 32'(max0), 32'(vt[i].exp_maxrd));
         check("vec_rdy", 32'(u_if0.rdy), 32'd0);
      end

      base = p0;
      pulse_en0();
      repeat (30) @(negedge clk);
      check("done_en_pulses", 32'(p0 - base), 32'd0);
      check("done_en_rdy", 32'(u_if0.rdy), 32'd0);
      check("done_en_key", 32'(u_if0.key), 32'd4);
      check("done_en_valid", 32'(u_if0.key_valid), 32'd1);

      load(vt[0]);
      do_reset();
      base = p0;
      pulse_en0();
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (u_if0.arc4_en) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("stop_launch_seen", 32'(ok), 32'd1);
      @(posedge clk);
      #1 u_if0.stop = 1'b1;
      @(posedge clk);
      #1;
`ifdef KEY_SEARCH_STOP_EN
      check("stop_rdy", 32'(u_if0.rdy), 32'd0);
      check("stop_valid", 32'(u_if0.key_valid), 32'd0);
      u_if0.stop = 1'b0;
      repeat (100) @(negedge clk);
      check("stop_held_valid", 32'(u_if0.key_valid), 32'd0);
      check("stop_pulses", 32'(p0 - base), 32'd1);
`else
      u_if0.stop = 1'b0;
      wait_valid0(ok);
      check("nostop_timeout", 32'(ok), 32'd1);
      check("nostop_key", 32'(u_if0.key), 32'd5);
      check("nostop_pulses", 32'(p0 - base), 32'd5);
`endif

      do_reset();
      pulse_en0();
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (u_if0.pt_addr == 8'd1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rdchr_seen", 32'(ok), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_arc4_en", 32'(u_if0.arc4_en), 32'd0);
      check("mid_rst_arc4_key", 32'(u_if0.arc4_key), 32'd0);
      check("mid_rst_pt_addr", 32'(u_if0.pt_addr), 32'd0);
      check("mid_rst_key", 32'(u_if0.key), 32'd0);
      check("mid_rst_valid", 32'(u_if0.key_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rdy", 32'(u_if0.rdy), 32'd1);
      check("post_rst_arc4_en", 32'(u_if0.arc4_en), 32'd0);
      base = p0;
      pulse_en0();
      check("restart_key", 32'(u_if0.arc4_key), 32'd1);
      wait_valid0(ok);
      check("restart_timeout", 32'(ok), 32'd1);
      check("restart_found", 32'(u_if0.key), 32'd5);
      check("restart_pulses", 32'(p0 - base), 32'd5);

      do_reset();
      base1 = p1;
      base2 = p2;
      u_if1.en = 1'b1;
      u_if2.en = 1'b1;
      @(negedge clk);
      u_if1.en = 1'b0;
      u_if2.en = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (u_if2.key_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("step2_timeout", 32'(ok), 32'd1);
      check("step2_key", 32'(u_if2.key), 32'd7);
      check("step2_pulses", 32'(p2 - base2), 32'd4);
      repeat (300) @(negedge clk);
      check("exh_valid", 32'(u_if1.key_valid), 32'd0);
      check("exh_rdy", 32'(u_if1.rdy), 32'd0);
      check("exh_key", 32'(u_if1.key), 32'd0);
      check("exh_pulses", 32'(p1 - base1), 32'd3);
      check("exh_last_key", 32'(u_if1.arc4_key), 32'hFFFFFF);

      check("arc4_en_rules", 32'(viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_search.md
KEY_SEARCH -- requirements
Module: key_search

Interface
REQ-001 Parameter KEY_START, default 24'h000000: first candidate key tried.
REQ-002 Parameter KEY_STEP, default 1: candidate increment; 2 used for interleaved dual-search instances.
REQ-003 Port clk  in  1  system clock; all state changes on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port en  in  1  start request; accepted only in the cycle en=1 and rdy=1.
REQ-006 Port rdy  out  1  high only in IDLE.
REQ-007 Port arc4_key  out  24  candidate key driven to the downstream ARC4 core.
REQ-008 Port arc4_en  out  1  one-cycle start pulse to the ARC4 core.
REQ-009 Port arc4_rdy  in  1  ARC4 core idle/finished; the plaintext memory is valid when it is high.
REQ-010 Port pt_addr  out  8  plaintext memory read address.
REQ-011 Port pt_rddata  in  8  plaintext read data, valid exactly one cycle after pt_addr is presented.
REQ-012 Port stop  in  1  abort request from a sibling search instance.
REQ-013 Port key  out  24  found key; meaningful only when key_valid=1.
REQ-014 Port key_valid  out  1  high when search ended with a printable plaintext.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT, RD_LEN, RD_CHR, CHECK, NEXT, DONE.
REQ-016 IDLE: on en&rdy load cand=KEY_START, clear key_valid, go LAUNCH.
REQ-017 LAUNCH: wait for arc4_rdy=1, then drive arc4_key=cand and arc4_en=1 for exactly one cycle, go WAIT.
REQ-018 WAIT: ignore arc4_rdy in the first cycle after the pulse; go RD_LEN on first later cycle with arc4_rdy=1.
REQ-019 RD_LEN: pt_addr=0; next cycle latch len=pt_rddata, idx=1.
REQ-020 len=0 SHALL count as printable: key=cand, key_valid=1, go DONE.
REQ-021 RD_CHR/CHECK: present pt_addr=idx, check pt_rddata next cycle; printable means 8'h20..8'h7E inclusive.
REQ-022 Non-printable byte SHALL end the check immediately and go NEXT (no further reads).
REQ-023 idx=len with printable byte: key=cand, key_valid=1, go DONE.
REQ-024 NEXT: cand=cand+KEY_STEP in 25-bit arithmetic; carry out of bit 23 means exhausted: key_valid=0, go DONE; else LAUNCH.
REQ-025 KEY_STEP=2, KEY_START=1 SHALL try 1,3,...,FFFFFF then exhaust; KEY_START=0 SHALL end at FFFFFE.
REQ-026 DONE: rdy=0, outputs held until reset; a new en SHALL be ignored.
REQ-027 arc4_en SHALL never be asserted outside LAUNCH, and never while arc4_rdy=0.
REQ-028 key/key_valid SHALL change only on the DONE transition (or reset).

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, rdy=1 after release, arc4_en=0, arc4_key=0, pt_addr=0, key=0, key_valid=0, cand=0.
REQ-030 Reset mid-search SHALL abandon the candidate; no arc4_en pulse in the cycle after release.

Configuration
REQ-031 Macro KEY_SEARCH_STOP_EN defined: stop=1 in any state except IDLE/DONE forces DONE next cycle with key_valid=0, unless the same cycle completes a success (success wins).
REQ-032 Macro KEY_SEARCH_STOP_EN undefined: stop SHALL be ignored entirely; port retained.

Verification
REQ-033 Model ARC4 with 3-cycle busy; plaintext len=3 "abc", accepted at cand=0x000005 -> key=0x000005, key_valid=1, five arc4_en pulses.
REQ-034 len=0 at first candidate -> key=KEY_START, key_valid=1 after one arc4_en pulse.
REQ-035 Byte 8'h7F at idx 1 for all keys, KEY_START=0xFFFFFD -> three candidates tried, key_valid=0, DONE, rdy=0.
REQ-036 KEY_STEP=2, KEY_START=1, match at 0x000004 never hit, match at 0x000007 -> key=0x000007 after 4 pulses.
REQ-037 With KEY_SEARCH_STOP_EN, stop=1 during WAIT -> DONE next cycle, key_valid=0; without macro -> search continues.
REQ-038 rst_n low for 1 cycle during RD_CHR -> all outputs zero immediately, rdy=1 after release, fresh en restarts at KEY_START.
